// File: rtl/complex_mult_pipe_if.sv
// Valid/ready stream bundle for complex_mult_pipe: operand side in, {re,im} result side out.
// Carries the conj operand qualifier only when CMULT_CONJ_EN is defined.
interface complex_mult_pipe_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned OW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] c;
    logic signed [DW-1:0] d;
`ifdef CMULT_CONJ_EN
    logic                 conj;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*OW-1:0]      out;
    logic [1:0]           ovf;

    modport master (
`ifdef CMULT_CONJ_EN
        output conj,
`endif
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
`ifdef CMULT_CONJ_EN
        input  conj,
`endif
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/complex_mult_pipe.sv
// Three-stage signed fixed-point complex multiplier with round-half-up and saturation.
// Optional CMULT_CONJ_EN adds a conj qualifier that multiplies by the conjugate of y.
module complex_mult_pipe #(
    parameter int unsigned DW   = 16,
    parameter int unsigned OW   = 16,
    parameter int unsigned FRAC = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    complex_mult_pipe_if.slave bus
);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = 2 * DW + 1;

    generate
        if (FRAC < 1 || FRAC >= 2 * DW || OW > 2 * DW + 1 - FRAC) begin : g_bad_params
            $error("complex_mult_pipe: illegal DW/OW/FRAC combination");
        end
    endgenerate

    localparam logic signed [SW:0] RND  = (SW + 1)'(1) << (FRAC - 1);
    localparam logic signed [SW:0] MAXV = {{(SW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [SW:0] MINV = ~MAXV;

    // Round half toward +inf, then clip; MSB of the result flags a clip.
    function automatic logic [OW:0] round_sat(input logic signed [SW:0] full);
        logic signed [SW:0] sh;
        sh = (full + RND) >>> FRAC;
        if (sh > MAXV)      round_sat = {1'b1, MAXV[OW-1:0]};
        else if (sh < MINV) round_sat = {1'b1, MINV[OW-1:0]};
        else                round_sat = {1'b0, sh[OW-1:0]};
    endfunction

    logic                 adv;
    logic signed [PW-1:0] ac_c, bd_c, ad_c, bc_c;
    logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
    logic signed [SW-1:0] re_sum_c, im_sum_c;
    logic signed [SW-1:0] re_full, im_full;
    logic [OW:0]          re_rs_c, im_rs_c;
    logic                 v1, v2;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign ac_c = PW'(bus.a) * PW'(bus.c);
    assign bd_c = PW'(bus.b) * PW'(bus.d);
    assign ad_c = PW'(bus.a) * PW'(bus.d);
    assign bc_c = PW'(bus.b) * PW'(bus.c);

`ifdef CMULT_CONJ_EN
    logic conj1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   conj1 <= 1'b0;
        else if (adv) conj1 <= bus.conj;
    end

    assign re_sum_c = conj1 ? (SW'(p_ac) + SW'(p_bd)) : (SW'(p_ac) - SW'(p_bd));
    assign im_sum_c = conj1 ? (SW'(p_bc) - SW'(p_ad)) : (SW'(p_ad) + SW'(p_bc));
`else
    assign re_sum_c = SW'(p_ac) - SW'(p_bd);
    assign im_sum_c = SW'(p_ad) + SW'(p_bc);
`endif

    assign re_rs_c = round_sat((SW + 1)'(re_full));
    assign im_rs_c = round_sat((SW + 1)'(im_full));

    // Whole pipe moves in lock-step on adv; bubbles travel with their valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            p_ac          <= '0;
            p_bd          <= '0;
            p_ad          <= '0;
            p_bc          <= '0;
            v2            <= 1'b0;
            re_full       <= '0;
            im_full       <= '0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.ovf       <= '0;
        end else if (adv) begin
            v1            <= bus.in_valid;
            p_ac          <= ac_c;
            p_bd          <= bd_c;
            p_ad          <= ad_c;
            p_bc          <= bc_c;
            v2            <= v1;
            re_full       <= re_sum_c;
            im_full       <= im_sum_c;
            bus.out_valid <= v2;
            bus.out       <= {re_rs_c[OW-1:0], im_rs_c[OW-1:0]};
            bus.ovf       <= {re_rs_c[OW], im_rs_c[OW]};
        end
    end
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: arithmetic reference model, scoreboard monitor and directed vectors.
module tb_complex_mult_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    complex_mult_pipe_if #(.DW(16), .OW(16)) bif ();
    complex_mult_pipe #(.DW(16), .OW(16), .FRAC(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int          checks = 0;
    int          errors = 0;
    int          tx_cnt = 0;
    int          rx_cnt = 0;
    logic [33:0] exp_q[$];
    logic        stream_done = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Plain integer complex product, Q15 rounding half up, clamp to 16 bits.
    function automatic logic [33:0] model(input logic [15:0] xa, xb, xc, xd, input logic cj);
        longint a, b, c, d, re, im, rr, ri;
        logic   ovr, ovi;
        a = longint'($signed(xa)); b = longint'($signed(xb));
        c = longint'($signed(xc)); d = longint'($signed(xd));
        re = cj ? (a * c + b * d) : (a * c - b * d);
        im = cj ? (b * c - a * d) : (a * d + b * c);
        rr = (re + 16384) >>> 15;
        ri = (im + 16384) >>> 15;
        ovr = 1'b0; ovi = 1'b0;
        if (rr > 32767) begin rr = 32767; ovr = 1'b1; end
        if (rr < -32768) begin rr = -32768; ovr = 1'b1; end
        if (ri > 32767) begin ri = 32767; ovi = 1'b1; end
        if (ri < -32768) begin ri = -32768; ovi = 1'b1; end
        return {16'(rr), 16'(ri), ovr, ovi};
    endfunction

    // Scoreboard: every accepted operand set must emerge once, in order, held while stalled.
    initial begin
        logic        stalled;
        logic [33:0] held;
        logic        cj;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("stall_hold", 64'({bif.out_valid, bif.out, bif.ovf}), 64'({1'b1, held}));
                if (bif.out_valid && bif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %0h expected no result", bif.out);
                    end else begin
                        check("stream_out", 64'({bif.out, bif.ovf}), 64'(exp_q.pop_front()));
                        rx_cnt++;
                    end
                end
                stalled = bif.out_valid && !bif.out_ready;
                held    = {bif.out, bif.ovf};
                if (bif.in_valid && bif.in_ready) begin
`ifdef CMULT_CONJ_EN
                    cj = bif.conj;
`else
                    cj = 1'b0;
`endif
                    exp_q.push_back(model(bif.a, bif.b, bif.c, bif.d, cj));
                    tx_cnt++;
                end
            end
        end
    end

    task automatic drive(input logic [15:0] a, b, c, d, input logic cj);
        bif.a = a; bif.b = b; bif.c = c; bif.d = d;
`ifdef CMULT_CONJ_EN
        bif.conj = cj;
`else
        if (cj) $display("conj request ignored in this build");
`endif
        bif.in_valid = 1'b1;
    endtask

    // Single isolated sample: pins the model, the latency and the DUT result.
    task automatic run_vec(input string name, input logic [15:0] a, b, c, d, input logic cj,
                           input logic [31:0] eo, input logic [1:0] ev);
        int lat;
        check({name, "_model"}, 64'(model(a, b, c, d, cj)), 64'({eo, ev}));
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        drive(a, b, c, d, cj);
        @(negedge clk);
        check({name, "_in_ready"}, 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 0;
        while (!bif.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_out"}, 64'(bif.out), 64'(eo));
        check({name, "_ovf"}, 64'(bif.ovf), 64'(ev));
    endtask

    initial begin
        int tx0, rx0, w;
        logic [15:0] r0, r1, r2, r3;
        bif.in_valid = 1'b0; bif.out_ready = 1'b0;
        bif.a = '0; bif.b = '0; bif.c = '0; bif.d = '0;
`ifdef CMULT_CONJ_EN
        bif.conj = 1'b0;
`endif
        #12;
        check("reset_out_valid", 64'(bif.out_valid), 64'd0);
        check("reset_out", 64'(bif.out), 64'd0);
        check("reset_ovf", 64'(bif.ovf), 64'd0);
        check("reset_in_ready", 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_vec("real_x_real", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h2000_0000, 2'b00);
        run_vec("cross_terms", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0, 32'h0000_4000, 2'b00);
        run_vec("neg_corner",  16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 32'h7FFF_0000, 2'b10);
        run_vec("re_sat_only", 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, 32'h7FFF_0001, 2'b10);
        run_vec("im_neg_sat",  16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 32'h0002_8000, 2'b01);
        run_vec("rnd_neg_half", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0000_0000, 2'b00);
        run_vec("rnd_pos_half", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0001_0000, 2'b00);
        run_vec("rnd_neg_1p5",  16'hFFFD, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'hFFFF_0000, 2'b00);
`ifdef CMULT_CONJ_EN
        run_vec("conj_on",  16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 32'h4000_0000, 2'b00);
        run_vec("conj_off", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0, 32'h0000_4000, 2'b00);
`endif

        // Reset with samples in flight: first result just presented, two more behind it.
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(16'h1000 + 16'(i), 16'h0200, 16'h3000, 16'h0100, 1'b0);
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        check("midrst_pre_valid", 64'(bif.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bif.out_valid), 64'd0);
        check("midrst_ovf", 64'(bif.ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(bif.out_valid), 64'd0);
        end

        // Random operands with random backpressure.
        tx0 = tx_cnt;
        rx0 = rx_cnt;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    r0 = 16'($urandom); r1 = 16'($urandom);
                    r2 = 16'($urandom); r3 = 16'($urandom);
                    if (i == 3) begin r0 = 16'h8000; r1 = 16'h0000; r2 = 16'h8000; r3 = 16'h0000; end
                    drive(r0, r1, r2, r3, 1'($urandom_range(0, 1)));
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!bif.in_ready && w < 50);
                    if (w >= 50) begin
                        checks++;
                        errors++;
                        $display("FAIL bp_accept_timeout: got no accept expected accept within 50");
                    end
                    @(posedge clk); #1;
                end
                bif.in_valid = 1'b0;
                stream_done  = 1'b1;
            end
            begin
                while (!stream_done) begin
                    bif.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        bif.out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_tx_count", 64'(tx_cnt - tx0), 64'd12);
        check("bp_rx_count", 64'(rx_cnt - rx0), 64'(tx_cnt - tx0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
